shift_word_serializer: RTL and testbench

//  Parallel-to-serial feeder for the bidirectional shift register stage.
//  - Accepts one WIDTH-bit word per valid/ready handshake.
//  - Drives it bit-serially onto the shift register's d/en/dir inputs.
//  - After WIDTH enabled shifts, the downstream register holds the word

---
 rtl/shift_word_serializer.sv | 97 +++++++++
 tb/tb_shift_word_serializer.sv | 83 ++++++++
 2 files changed

// File: rtl/shift_word_serializer.sv
// shift_word_serializer: feeds one word at a time bit-serially into a bidirectional shift register
module shift_word_serializer #(
  parameter int WIDTH = 4,
  parameter int GAP = 0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sr_d,
  output logic             sr_en,
  output logic             sr_dir,
  output logic             word_done,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int GW = GAP > 0 ? $clog2(GAP + 1) : 1;
  localparam logic [CW-1:0] CLAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GLAST = GW'(GAP > 0 ? GAP - 1 : 0);
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic dir_q, dir_d;
  logic in_ready_q, in_ready_d, sr_d_q, sr_d_d, sr_en_q, sr_en_d;
  logic word_done_q, word_done_d, busy_q, busy_d;
  // word_q holds the bits still to send, pre-shifted so the next bit is always at the end facing dir
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    gcnt_d = gcnt_q;
    word_d = word_q;
    dir_d = dir_q;
    sr_d_d = 1'b0;
    sr_en_d = 1'b0;
    word_done_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (in_valid) begin
        state_d = S_SHIFT;
        cnt_d = '0;
        dir_d = in_dir;
        word_d = in_dir ? in_data >> 1 : in_data << 1;
        sr_d_d = in_dir ? in_data[0] : in_data[WIDTH-1];
        sr_en_d = 1'b1;
      end
      S_SHIFT: if (cnt_q == CLAST) begin
        state_d = GAP > 0 ? S_GAP : S_IDLE;
        gcnt_d = '0;
        word_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
        sr_d_d = dir_q ? word_q[0] : word_q[WIDTH-1];
        sr_en_d = 1'b1;
        word_d = dir_q ? word_q >> 1 : word_q << 1;
      end
      S_GAP: if (gcnt_q == GLAST) state_d = S_IDLE;
             else gcnt_d = gcnt_q + 1'b1;
      default: state_d = S_IDLE;
    endcase
    in_ready_d = state_d == S_IDLE;
    busy_d = state_d != S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      gcnt_q <= '0;
      word_q <= '0;
      dir_q <= 1'b0;
      in_ready_q <= 1'b1;
      sr_d_q <= 1'b0;
      sr_en_q <= 1'b0;
      word_done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gcnt_q <= gcnt_d;
      word_q <= word_d;
      dir_q <= dir_d;
      in_ready_q <= in_ready_d;
      sr_d_q <= sr_d_d;
      sr_en_q <= sr_en_d;
      word_done_q <= word_done_d;
      busy_q <= busy_d;
    end
  end
  assign in_ready = in_ready_q;
  assign sr_d = sr_d_q;
  assign sr_en = sr_en_q;
  assign sr_dir = dir_q;
  assign word_done = word_done_q;
  assign busy = busy_q;
endmodule

// File: tb/tb_shift_word_serializer.sv
// tb_shift_word_serializer: random traffic on two configurations, checked against a cycle-indexed word model
module tb_shift_word_serializer;
  logic clk = 1'b0;
  int total = 0;
  int bad = 0;
  int fin = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int W = g ? 8 : 4;
    localparam int G = g ? 2 : 0;
    logic rstn, in_valid, in_dir, in_ready, sr_d, sr_en, sr_dir, word_done, busy;
    logic [W-1:0] in_data, ds;
    shift_word_serializer #(.WIDTH(W), .GAP(G)) dut (
      .clk(clk), .rstn(rstn), .in_data(in_data), .in_dir(in_dir), .in_valid(in_valid),
      .in_ready(in_ready), .sr_d(sr_d), .sr_en(sr_en), .sr_dir(sr_dir),
      .word_done(word_done), .busy(busy)
    );
    // downstream bidirectional shift register sharing rstn
    always_ff @(posedge clk)
      ds <= !rstn ? '0 : !sr_en ? ds : sr_dir ? {sr_d, ds[W-1:1]} : {ds[W-2:0], sr_d};
    initial begin
      int e, acc, k;
      bit act, mdir, ready, on, en;
      logic [W-1:0] mw;
      e = 0; acc = 0; act = 0; mdir = 0; mw = '0;
      rstn = 1'b0; in_valid = 1'b0; in_data = '0; in_dir = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk($sformatf("w%0d reset in_ready", W), 32'(in_ready), 1);
      chk($sformatf("w%0d reset busy", W), 32'(busy), 0);
      chk($sformatf("w%0d reset sr_en", W), 32'(sr_en), 0);
      chk($sformatf("w%0d reset sr_d", W), 32'(sr_d), 0);
      chk($sformatf("w%0d reset sr_dir", W), 32'(sr_dir), 0);
      chk($sformatf("w%0d reset done", W), 32'(word_done), 0);
      for (int c = 0; c < 1500; c++) begin
        rstn = $urandom_range(0, 59) != 0;
        in_valid = (c % 200 < 60) ? 1'b1 : ($urandom_range(0, 3) != 0);
        in_data = W'($urandom);
        in_dir = 1'($urandom);
        @(posedge clk);
        if (!rstn) begin
          act = 0;
          mdir = 0;
        end else begin
          ready = !act || (e - acc) >= W + G;
          if (ready && in_valid) begin
            act = 1;
            acc = e + 1;
            mw = in_data;
            mdir = in_dir;
          end
        end
        e++;
        @(negedge clk);
        k = e - acc;
        on = act && k < W + G;
        en = act && k < W;
        chk($sformatf("w%0d in_ready", W), 32'(in_ready), 32'(!on));
        chk($sformatf("w%0d busy", W), 32'(busy), 32'(on));
        chk($sformatf("w%0d sr_en", W), 32'(sr_en), 32'(en));
        chk($sformatf("w%0d sr_d", W), 32'(sr_d), en ? 32'(mdir ? mw[k] : mw[W-1-k]) : 0);
        chk($sformatf("w%0d sr_dir", W), 32'(sr_dir), 32'(mdir));
        chk($sformatf("w%0d word_done", W), 32'(word_done), 32'(act && k == W));
        if (act && k == W) chk($sformatf("w%0d downstream", W), 32'(ds), 32'(mw));
        if (!rstn) chk($sformatf("w%0d downstream reset", W), 32'(ds), 0);
      end
      fin++;
    end
  end
  initial begin
    for (int i = 0; i < 20000 && fin < 2; i++) @(posedge clk);
    if (fin < 2) chk("timeout", 32'(fin), 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
